// File: rtl/if_stage_unit.sv
// rtl/if_stage_unit.sv - MIPS instruction-fetch stage: PC, IF/ID register, redirect/stall/halt, run-cycle counter
module if_stage_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               stall,
  input  logic               ex_redirect,
  input  logic [31:0]        ex_target,
  input  logic               halt_req,
  input  logic               resume,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_cnt
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc[IMEM_AW+1:2];
  assign halted    = (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          // Every RUN edge counts, whatever else happens on it.
          cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (halt_req) begin
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            state       <= HALTED;
          end else if (ex_redirect) begin
            pc          <= ex_target;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
          end else if (!stall) begin
            pc          <= pc_plus4;
            if_id_instr <= imem_data;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
          end
        end
        HALTED: begin
          // pc and IF/ID hold; the held pc is refetched on the first RUN edge.
          if (resume && !halt_req) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
